// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired Moore control unit for the RISC CPU datapath. Steps through
//   fetch (T0-T2), decode (T3) and execute (T4-T7), driving the datapath
//   control strobes. Memory accesses are stretched to MEM_LAT cycles by a
//   small latency counter. Supports stop/restart through a HALT state and
//   flags undefined opcodes.
//
// Ports
//   clock       in   1        sole clock, rising edge
//   clear       in   1        asynchronous active-low reset
//   ir_opcode   in   OPW      IR opcode field, sampled in T3 only
//   stop        in   1        request HALT at the next instruction boundary
//   restart     in   1        leave HALT, next cycle is T0
//   PCout..Zlowout  out 1     datapath strobes
//   ramEnable   out  1        memory write strobe
//   alu_op      out  ALU_OPW  ALU function (ADD=0, SUB=1, AND=2, OR=3), 0 unless Zin
//   run         out  1        high in every state except IDLE and HALT
//   illegal_op  out  1        one-cycle pulse in T3 on an undefined opcode
//   state_code  out  4        current state encoding for debug

module control_sequencer #(
    parameter int OPW     = 5,
    parameter int MEM_LAT = 1,
    parameter int ALU_OPW = 4
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [OPW-1:0]     ir_opcode,
    input  logic               stop,
    input  logic               restart,
    output logic               PCout,
    output logic               IncPC,
    output logic               MARin,
    output logic               memRead,
    output logic               MDRin,
    output logic               MDRout,
    output logic               IRin,
    output logic               Gra,
    output logic               Grb,
    output logic               Grc,
    output logic               Rin,
    output logic               Rout,
    output logic               BAout,
    output logic               Yin,
    output logic               Cout,
    output logic               Zin,
    output logic               Zlowout,
    output logic               ramEnable,
    output logic [ALU_OPW-1:0] alu_op,
    output logic               run,
    output logic               illegal_op,
    output logic [3:0]         state_code
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'(MEM_LAT - 1);

    localparam logic [ALU_OPW-1:0] ALU_ADD = ALU_OPW'(0);
    localparam logic [ALU_OPW-1:0] ALU_SUB = ALU_OPW'(1);
    localparam logic [ALU_OPW-1:0] ALU_AND = ALU_OPW'(2);
    localparam logic [ALU_OPW-1:0] ALU_OR  = ALU_OPW'(3);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        K_NONE, K_REG, K_IMM, K_LDI, K_LD, K_ST, K_NOP, K_HALT, K_ILL
    } kind_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         lat_cnt;
    logic                  lat_done;
    logic                  lat_state;
    kind_t                 dec_kind;
    kind_t                 kind_q;
    logic [ALU_OPW-1:0]    dec_alu;
    logic [ALU_OPW-1:0]    alu_q;
    logic [31:0]           op_val;
    state_t                fin_state;

    assign op_val    = 32'(ir_opcode);
    assign lat_done  = (lat_cnt == LAT_LAST);
    assign lat_state = (state == S_T1) || (state == S_T6) || (state == S_T7);
    // Where an instruction goes after its last cycle.
    assign fin_state = stop ? S_HALT : S_T0;

    // Opcode decode; only meaningful in T3, latched into kind_q/alu_q there
    // so the execute steps no longer depend on ir_opcode.
    always_comb begin
        dec_kind = K_ILL;
        dec_alu  = ALU_ADD;
        case (op_val)
            32'd0:  dec_kind = K_LD;
            32'd1:  dec_kind = K_LDI;
            32'd2:  dec_kind = K_ST;
            32'd3:  dec_kind = K_REG;
            32'd4:  begin dec_kind = K_REG; dec_alu = ALU_SUB; end
            32'd5:  begin dec_kind = K_REG; dec_alu = ALU_AND; end
            32'd6:  begin dec_kind = K_REG; dec_alu = ALU_OR;  end
            32'd12: dec_kind = K_IMM;
            32'd13: begin dec_kind = K_IMM; dec_alu = ALU_AND; end
            32'd14: begin dec_kind = K_IMM; dec_alu = ALU_OR;  end
            32'd26: dec_kind = K_NOP;
            32'd27: dec_kind = K_HALT;
            default: dec_kind = K_ILL;
        endcase
    end

    // State, latency counter and latched instruction class.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= S_IDLE;
            lat_cnt <= '0;
            kind_q  <= K_NONE;
            alu_q   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                lat_cnt <= '0;
            end else if (lat_state) begin
                lat_cnt <= lat_cnt + CW'(1);
            end
            if (state == S_T3) begin
                kind_q <= dec_kind;
                alu_q  <= dec_alu;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: state_next = S_T0;
            S_T0:   state_next = S_T1;
            S_T1:   state_next = lat_done ? S_T2 : S_T1;
            S_T2:   state_next = S_T3;
            S_T3: begin
                case (dec_kind)
                    K_NOP, K_ILL: state_next = fin_state;
                    K_HALT:       state_next = S_HALT;
                    default:      state_next = S_T4;
                endcase
            end
            S_T4:   state_next = S_T5;
            S_T5:   state_next = (kind_q == K_LD || kind_q == K_ST) ? S_T6 : fin_state;
            S_T6: begin
                if (kind_q == K_LD) begin
                    state_next = lat_done ? S_T7 : S_T6;
                end else begin
                    state_next = S_T7;
                end
            end
            S_T7: begin
                if (kind_q == K_ST) begin
                    state_next = lat_done ? fin_state : S_T7;
                end else begin
                    state_next = fin_state;
                end
            end
            S_HALT: state_next = restart ? S_T0 : S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // Moore output decode. T3 additionally looks at the live opcode because
    // the instruction class is only known during that cycle.
    always_comb begin
        PCout = 1'b0; IncPC = 1'b0; MARin = 1'b0; memRead = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Gra = 1'b0;
        Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; Yin = 1'b0; Cout = 1'b0; Zin = 1'b0;
        Zlowout = 1'b0; ramEnable = 1'b0; alu_op = '0; illegal_op = 1'b0;
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            S_T1: begin memRead = 1'b1; MDRin = lat_done; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (dec_kind)
                    K_REG, K_IMM:       begin Grb = 1'b1; Rout = 1'b1;  Yin = 1'b1; end
                    K_LDI, K_LD, K_ST:  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    K_ILL:              illegal_op = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (kind_q)
                    K_REG: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = alu_q; end
                    K_IMM: begin Cout = 1'b1; Zin = 1'b1; alu_op = alu_q; end
                    K_LDI, K_LD, K_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
                    default: ;
                endcase
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (kind_q == K_LD || kind_q == K_ST) begin
                    MARin = 1'b1;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T6: begin
                if (kind_q == K_LD) begin
                    memRead = 1'b1; MDRin = lat_done;
                end else begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end
            end
            S_T7: begin
                if (kind_q == K_ST) begin
                    ramEnable = 1'b1;
                end else begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign run        = (state != S_IDLE) && (state != S_HALT);
    assign state_code = state;

endmodule
